// File: rtl/msdap_pkg.sv
// Shared constants and FSM encoding for the MSDAP output serializer.
package msdap_pkg;

  localparam int WORD_W   = 40;  // result width and serial frame length
  localparam int SKEW_MAX = 32;  // cycles a lone channel waits for its partner

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } p2s_state_e;

endpackage

// File: rtl/p2s_channel.sv
// One serializer lane: holding register, pending flag, shift register,
// registered serial output and sticky overrun detect.
module p2s_channel #(
  parameter int W = 40
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         cap_en,    // capture acc into the holding register
  input  logic [W-1:0] acc,
  input  logic         load,      // frame launch / back-to-back reload
  input  logic         shift,     // advance one bit within a frame
  output logic         pend,
  output logic         ser_out,
  output logic         overrun
);

  logic [W-1:0] hold_q, hold_d;
  logic [W-1:0] sh_q, sh_d;
  logic         pend_q, pend_d;
  logic         out_q, out_d;
  logic         ovr_q, ovr_d;
  logic         consume;

  // A launch consumes the old hold value even if a new capture lands on the
  // same edge; that case keeps pend set and is not an overrun.
  always_comb begin
    consume = load & pend_q;
    hold_d  = cap_en ? acc : hold_q;
    pend_d  = cap_en ? 1'b1 : (consume ? 1'b0 : pend_q);
    ovr_d   = ovr_q | (cap_en & pend_q & ~consume);
    sh_d    = sh_q;
    out_d   = 1'b0;
    if (load) begin
      sh_d  = pend_q ? hold_q : '0;
      out_d = pend_q & hold_q[W-1];
    end else if (shift) begin
      sh_d  = sh_q << 1;
      out_d = sh_q[W-2];
    end
  end

  // Lane state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_q <= '0;
      sh_q   <= '0;
      pend_q <= 1'b0;
      out_q  <= 1'b0;
      ovr_q  <= 1'b0;
    end else begin
      hold_q <= hold_d;
      sh_q   <= sh_d;
      pend_q <= pend_d;
      out_q  <= out_d;
      ovr_q  <= ovr_d;
    end
  end

  assign pend    = pend_q;
  assign ser_out = out_q;
  assign overrun = ovr_q;

endmodule

// File: rtl/output_serializer.sv
// Final MSDAP stage: captures left/right 40-bit results and shifts them out
// MSB-first in lock-step, framed by OutReady. A lone pending channel is
// forced out with a zero partner after SKEW_MAX cycles.
// Optional build macro P2S_FRAME_CNT_EN adds frame_cnt / forced_cnt outputs.
//
// Handshake: p2sX_en is a one-cycle valid pulse with no ready; the block
// always accepts. OutputL/OutputR are valid exactly while OutReady is high.
module output_serializer
  import msdap_pkg::*;
(
  input  logic              Sclk,
  input  logic              Clear,
  input  logic              p2sL_en,
  input  logic              p2sR_en,
  input  logic [WORD_W-1:0] accL,
  input  logic [WORD_W-1:0] accR,
  output logic              OutReady,
  output logic              OutputL,
  output logic              OutputR,
  output logic              state_dbg,
  output logic              overrun
`ifdef P2S_FRAME_CNT_EN
  ,
  output logic [15:0]       frame_cnt,
  output logic [7:0]        forced_cnt
`endif
);

  localparam int BIT_W  = $clog2(WORD_W);
  localparam int SKEW_W = $clog2(SKEW_MAX) + 1;
  localparam logic [BIT_W-1:0]  LAST_BIT = BIT_W'(WORD_W - 1);
  localparam logic [SKEW_W-1:0] SKEW_TOP = SKEW_W'(SKEW_MAX - 1);

  p2s_state_e        state_q, state_d;
  logic [BIT_W-1:0]  bitcnt_q, bitcnt_d;
  logic [SKEW_W-1:0] skew_q, skew_d;
  logic              ready_q, ready_d;

  logic pend_l, pend_r, ovr_l, ovr_r;
  logic last_bit, timeout, launch_cond, launch, shift_en;

  p2s_channel #(.W(WORD_W)) u_chan_l (
    .clk(Sclk), .rst(Clear), .cap_en(p2sL_en), .acc(accL),
    .load(launch), .shift(shift_en),
    .pend(pend_l), .ser_out(OutputL), .overrun(ovr_l)
  );

  p2s_channel #(.W(WORD_W)) u_chan_r (
    .clk(Sclk), .rst(Clear), .cap_en(p2sR_en), .acc(accR),
    .load(launch), .shift(shift_en),
    .pend(pend_r), .ser_out(OutputR), .overrun(ovr_r)
  );

  // Launch decode and next-state for the frame FSM, bit and skew counters.
  always_comb begin
    last_bit    = (state_q == ST_SHIFT) && (bitcnt_q == LAST_BIT);
    timeout     = (pend_l ^ pend_r) && (skew_q == SKEW_TOP);
    launch_cond = (pend_l & pend_r) | timeout;
    launch      = ((state_q == ST_IDLE) || last_bit) && launch_cond;
    shift_en    = (state_q == ST_SHIFT) && !last_bit;

    state_d  = state_q;
    bitcnt_d = bitcnt_q;
    ready_d  = ready_q;
    if (launch) begin
      state_d  = ST_SHIFT;
      bitcnt_d = '0;
      ready_d  = 1'b1;
    end else if (last_bit) begin
      state_d = ST_IDLE;
      ready_d = 1'b0;
    end else if (shift_en) begin
      bitcnt_d = bitcnt_q + 1'b1;
    end

    skew_d = '0;
    if ((state_q == ST_IDLE) && !launch && (pend_l ^ pend_r))
      skew_d = (skew_q == SKEW_TOP) ? skew_q : skew_q + 1'b1;
  end

  // Frame FSM and counters.
  always_ff @(posedge Sclk or posedge Clear) begin
    if (Clear) begin
      state_q  <= ST_IDLE;
      bitcnt_q <= '0;
      skew_q   <= '0;
      ready_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      bitcnt_q <= bitcnt_d;
      skew_q   <= skew_d;
      ready_q  <= ready_d;
    end
  end

  assign OutReady  = ready_q;
  assign state_dbg = state_q;
  assign overrun   = ovr_l | ovr_r;

`ifdef P2S_FRAME_CNT_EN
  logic [15:0] frame_q, frame_d;
  logic [7:0]  forced_q, forced_d;

  // Launch statistics: frames wrap, forced launches saturate.
  always_comb begin
    frame_d  = launch ? frame_q + 16'd1 : frame_q;
    forced_d = forced_q;
    if (launch && timeout && (forced_q != 8'hFF))
      forced_d = forced_q + 8'd1;
  end

  // Statistics registers.
  always_ff @(posedge Sclk or posedge Clear) begin
    if (Clear) begin
      frame_q  <= '0;
      forced_q <= '0;
    end else begin
      frame_q  <= frame_d;
      forced_q <= forced_d;
    end
  end

  assign frame_cnt  = frame_q;
  assign forced_cnt = forced_q;
`endif

endmodule

// File: tb/tb_output_serializer.sv
// Self-checking bench for output_serializer: drives captures on the falling
// edge, reassembles serial frames on the falling edge and compares them
// against expected words queued when the captures are driven.
module tb_output_serializer;

  localparam int W = 40;

  logic         Sclk = 1'b0;
  logic         Clear = 1'b1;
  logic         p2sL_en = 1'b0;
  logic         p2sR_en = 1'b0;
  logic [W-1:0] accL = '0;
  logic [W-1:0] accR = '0;
  logic         OutReady, OutputL, OutputR, state_dbg, overrun;
`ifdef P2S_FRAME_CNT_EN
  logic [15:0]  frame_cnt;
  logic [7:0]   forced_cnt;
`endif

  output_serializer dut (
    .Sclk(Sclk), .Clear(Clear), .p2sL_en(p2sL_en), .p2sR_en(p2sR_en),
    .accL(accL), .accR(accR), .OutReady(OutReady), .OutputL(OutputL),
    .OutputR(OutputR), .state_dbg(state_dbg), .overrun(overrun)
`ifdef P2S_FRAME_CNT_EN
    , .frame_cnt(frame_cnt), .forced_cnt(forced_cnt)
`endif
  );

  // ---------------- clock ----------------
  always #5 Sclk = ~Sclk;

  // ---------------- scoreboard state ----------------
  logic [W-1:0] exp_l_q[$];
  logic [W-1:0] exp_r_q[$];
  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- frame monitor ----------------
  int           bit_cnt = 0;
  int           run_cnt = 0;
  int           last_run = 0;
  int           runs_done = 0;
  logic [W-1:0] sh_l = '0;
  logic [W-1:0] sh_r = '0;

  always @(negedge Sclk) begin
    if (Clear) begin
      bit_cnt = 0;
      run_cnt = 0;
      exp_l_q.delete();
      exp_r_q.delete();
    end else if (OutReady) begin
      run_cnt++;
      sh_l = {sh_l[W-2:0], OutputL};
      sh_r = {sh_r[W-2:0], OutputR};
      bit_cnt++;
      if (bit_cnt == W) begin
        bit_cnt = 0;
        if (exp_l_q.size() == 0 || exp_r_q.size() == 0) begin
          check("frame_unexpected", 64'd1, 64'd0);
        end else begin
          check("frame_left", 64'(sh_l), 64'(exp_l_q.pop_front()));
          check("frame_right", 64'(sh_r), 64'(exp_r_q.pop_front()));
        end
      end
    end else if (run_cnt != 0) begin
      check("frame_partial_bits", 64'(bit_cnt), 64'd0);
      last_run  = run_cnt;
      run_cnt   = 0;
      bit_cnt   = 0;
      runs_done++;
    end
  end

  // ---------------- driver tasks ----------------
  function automatic logic [W-1:0] rand_word();
    logic [63:0] t;
    t = {$urandom(), $urandom()};
    return t[W-1:0];
  endfunction

  // Drive one cycle of enables/data, then advance to the next falling edge.
  task automatic drive_cycle(input logic el, input logic er,
                             input logic [W-1:0] a, input logic [W-1:0] b);
    p2sL_en = el;
    p2sR_en = er;
    if (el) accL = a;
    if (er) accR = b;
    @(negedge Sclk);
  endtask

  // One capture per channel at the given cycle offsets (-1 = never); returns
  // the offset at which OutReady is first seen, or -1 if it never rises.
  task automatic run_stim(input int l_at, input int r_at,
                          input logic [W-1:0] a, input logic [W-1:0] b,
                          output int first);
    exp_l_q.push_back(l_at >= 0 ? a : '0);
    exp_r_q.push_back(r_at >= 0 ? b : '0);
    first = -1;
    for (int i = 0; i < 60; i++) begin
      if (OutReady) begin
        first = i;
        break;
      end
      drive_cycle(i == l_at, i == r_at, a, b);
    end
    p2sL_en = 1'b0;
    p2sR_en = 1'b0;
  endtask

  task automatic wait_run(input int prev, input int max_cyc, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge Sclk);
      if (runs_done != prev) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic pulse_clear();
    Clear = 1'b1;
    @(negedge Sclk);
    @(negedge Sclk);
    Clear = 1'b0;
    @(negedge Sclk);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int           first;
    int           prev;
    bit           ok;
    logic [W-1:0] a, b, c, d;

    // Reset state while Clear is held.
    repeat (3) @(negedge Sclk);
    check("reset_outputs", {OutReady, OutputL, OutputR, overrun}, 4'b0);
    check("reset_state", state_dbg, 1'b0);
    Clear = 1'b0;
    repeat (5) @(negedge Sclk);

    // Clear pulsed mid-idle, then 100 quiet cycles.
    pulse_clear();
    for (int i = 0; i < 100; i++) begin
      check("idle_quiet", {OutReady, OutputL, OutputR, overrun}, 4'b0);
      @(negedge Sclk);
    end

    // Paired frame with the documented patterns.
    prev = runs_done;
    run_stim(0, 0, 40'h00_8001_0000, 40'hFF_7FFF_0000, first);
    check("paired_latency", 64'(first), 64'd2);
    wait_run(prev, 100, ok);
    check("paired_done", ok, 1'b1);
    check("paired_len", 64'(last_run), 64'd40);

    // Skewed channels: R arrives 10 cycles after L.
    prev = runs_done;
    a = rand_word(); b = rand_word();
    run_stim(0, 10, a, b, first);
    check("skew_latency", 64'(first), 64'd12);
    wait_run(prev, 100, ok);
    check("skew_done", ok, 1'b1);
    check("skew_len", 64'(last_run), 64'd40);

    // Timeout: lone left result forced out with a zero right word.
    prev = runs_done;
    a = rand_word();
    run_stim(0, -1, a, '0, first);
    check("timeout_latency", 64'(first), 64'd33);
    wait_run(prev, 100, ok);
    check("timeout_done", ok, 1'b1);
    check("timeout_len", 64'(last_run), 64'd40);
    prev = runs_done;
    repeat (50) @(negedge Sclk);
    check("timeout_pend_cleared", 64'(runs_done - prev), 64'd0);
    check("timeout_idle_ready", OutReady, 1'b0);

    // Capture on the launch edge: old values go out, new ones follow directly.
    prev = runs_done;
    a = rand_word(); b = rand_word(); c = rand_word(); d = rand_word();
    exp_l_q.push_back(a); exp_r_q.push_back(b);
    exp_l_q.push_back(c); exp_r_q.push_back(d);
    drive_cycle(1'b1, 1'b1, a, b);
    drive_cycle(1'b1, 1'b1, c, d);
    drive_cycle(1'b0, 1'b0, '0, '0);
    wait_run(prev, 150, ok);
    check("simul_done", ok, 1'b1);
    check("simul_len", 64'(last_run), 64'd80);
    check("simul_no_overrun", overrun, 1'b0);

    // Back-to-back: paired captures every 40 cycles, three frames.
    prev = runs_done;
    for (int i = 0; i < 84; i++) begin
      if (i % 40 == 0) begin
        a = rand_word(); b = rand_word();
        exp_l_q.push_back(a); exp_r_q.push_back(b);
        drive_cycle(1'b1, 1'b1, a, b);
      end else begin
        drive_cycle(1'b0, 1'b0, '0, '0);
      end
    end
    wait_run(prev, 150, ok);
    check("b2b_done", ok, 1'b1);
    check("b2b_len", 64'(last_run), 64'd120);
    check("b2b_no_overrun", overrun, 1'b0);

    // Overrun: second left capture while the first is still pending.
    prev = runs_done;
    a = rand_word(); c = rand_word();
    exp_l_q.push_back(c); exp_r_q.push_back('0);
    for (int i = 0; i < 6; i++)
      drive_cycle(i == 0 || i == 5, 1'b0, (i == 0) ? a : c, '0);
    check("overrun_set", overrun, 1'b1);
    wait_run(prev, 100, ok);
    check("overrun_frame_done", ok, 1'b1);
    repeat (10) @(negedge Sclk);
    check("overrun_sticky", overrun, 1'b1);
    pulse_clear();
    check("overrun_cleared", overrun, 1'b0);

    // Reset mid-frame, then a clean frame afterwards.
    a = rand_word(); b = rand_word();
    run_stim(0, 0, a, b, first);
    check("midreset_launch", 64'(first), 64'd2);
    repeat (17) @(negedge Sclk);
    #2 Clear = 1'b1;
    #1 check("midreset_async", {OutReady, OutputL, OutputR}, 3'b0);
    @(negedge Sclk);
    @(negedge Sclk);
    Clear = 1'b0;
    @(negedge Sclk);
    prev = runs_done;
    a = rand_word(); b = rand_word();
    run_stim(0, 0, a, b, first);
    check("post_reset_latency", 64'(first), 64'd2);
    wait_run(prev, 100, ok);
    check("post_reset_done", ok, 1'b1);
    check("post_reset_len", 64'(last_run), 64'd40);

    repeat (5) @(negedge Sclk);
    check("exp_q_empty", 64'(exp_l_q.size() + exp_r_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global watchdog.
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/output_serializer.md
Name: output_serializer

Overview:
- Final MSDAP stage. Sits directly downstream of the shift-add accumulators that the ALU controller sequences.
- Captures the 40-bit left and right filter results when the controller pulses p2sL_en / p2sR_en.
- Shifts both results out MSB-first, in lock-step, on OutputL / OutputR.
- Frames each 40-bit word with OutReady.

Parameters:
- WORD_W, 40: result word width and serial frame length in bits.
- SKEW_MAX, 32: Sclk cycles a lone pending channel waits for its partner before the frame is forced.

Ports:
- Sclk  input  1  system clock. All state updates on the rising edge; upstream drives on the falling edge.
- Clear  input  1  asynchronous, active-high reset.
- p2sL_en  input  1  one-cycle pulse: accL holds a finished left result.
- p2sR_en  input  1  one-cycle pulse: accR holds a finished right result.
- accL  input  WORD_W  left accumulator result, two's complement.
- accR  input  WORD_W  right accumulator result, two's complement.
- OutReady  output  1  high for exactly WORD_W consecutive cycles per frame.
- OutputL  output  1  left serial data, valid while OutReady=1.
- OutputR  output  1  right serial data, valid while OutReady=1.
- overrun  output  1  sticky: a holding register was overwritten before it was sent.

Behaviour:
- Reset: Clear=1 asynchronously forces:
  - OutReady=0, OutputL=0, OutputR=0, overrun=0.
  - holdL, holdR, shL, shR = 0; pendL=pendR=0; bitcnt=0; skewcnt=0; state=IDLE.
  - A frame in progress is aborted with no partial continuation; the holding contents are lost.
- Capture: p2sX_en=1 at an edge loads holdX<=accX and sets pendX. If pendX is already 1 and is not consumed by a launch at that same edge, set overrun. The new value overwrites the old one.
- FSM states: IDLE, SHIFT.
- IDLE:
  - Launch condition: (pendL & pendR), or (pendL ^ pendR with skewcnt==SKEW_MAX-1).
  - On launch: shX<=holdX for each pending channel and all zeros for a non-pending channel; clear the consumed pend flags; bitcnt<=0; state<=SHIFT.
  - OutReady=1 and OutputX=shX[WORD_W-1] are registered at that same edge, so the first bit is visible one cycle after the capture that completed the pair.
- skewcnt:
  - Increments in IDLE while exactly one pend flag is set.
  - Resets to 0 otherwise and on launch.
  - Saturates; never wraps.
- SHIFT:
  - Each edge: shX<=shX<<1; OutputX<=next MSB; bitcnt++.
  - At bitcnt==WORD_W-1: if the launch condition holds, reload immediately (back-to-back frames, OutReady stays 1, no gap). Otherwise state<=IDLE and OutReady<=0, OutputX<=0.
- Simultaneous capture and launch: the launch consumes the old hold value, and the hold register takes the new accX in the same edge. pend stays 1 and overrun is not set.
- Captures during SHIFT are legal. They only fill the holding registers.
- Output bit order is MSB first: bit 39 through bit 0, no sign manipulation.

Optional Feature:
- Macro: P2S_FRAME_CNT_EN.
- Defined:
  - Adds output frame_cnt [15:0], reset 0.
  - Increments on every launch and wraps 0xFFFF to 0.
  - Adds output forced_cnt [7:0], which counts timeout-forced launches and saturates at 0xFF.
- Undefined: neither port nor its counter exists. Core behaviour is identical.

Decomposition:
- Shared package msdap_pkg:
  - WORD_W default constant (40).
  - FSM state encoding for IDLE/SHIFT.
  - SKEW_MAX default.
- Natural sub-module: p2s_channel, instantiated twice (L/R). It holds holdX, pendX, shX and per-channel overrun detect.
- Top level owns the FSM, bitcnt, skewcnt, launch decode and optional counters.

Test Plan:
- Reset/idle: Clear pulsed mid-idle, no enables -> OutReady=0, OutputL=OutputR=0, overrun=0 for 100 cycles.
- Paired frame: accL=40'h00_8001_0000 and accR=40'hFF_7FFF_0000, p2sL_en & p2sR_en in the same cycle. Expect:
  - next cycle OutReady=1 for exactly 40 cycles;
  - serial streams reassemble to the exact inputs, MSB first.
- Skewed channels: p2sL_en at cycle 0, p2sR_en at cycle 10 -> frame starts cycle 11; OutputR carries accR, no zero-fill.
- Timeout: p2sL_en only, SKEW_MAX=32 -> launch at cycle 32; OutputR all zeros; pendL cleared.
- Back-to-back and overrun:
  - Both enables every 40 cycles -> OutReady held continuously high across 3 frames.
  - Second p2sL_en while pendL set and no launch -> overrun=1 and stays 1 until Clear.
- Reset mid-frame: Clear at bit 17 -> OutReady drops immediately (asynchronous). After release, the next paired capture produces a clean full 40-bit frame.
